// File: rtl/rx_block_assembler.sv
// rtl/rx_block_assembler.sv - receive-path byte-to-block assembler with valid/ready output
// Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module rx_block_assembler #(
  parameter int NUM_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_error,
  output logic [8*NUM_BYTES-1:0] block_out,
  output logic                   block_valid,
  input  logic                   block_ready,
  output logic [CNT_W-1:0]       byte_count,
  output logic                   busy,
  input  logic                   clr_err,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic                   frame_err
);

  localparam int BW = 8 * NUM_BYTES;

  // Parameter sanity: byte_count must hold NUM_BYTES, the shift needs at least two bytes.
  if (NUM_BYTES < 2 || NUM_BYTES >= (1 << CNT_W) || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("rx_block_assembler: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t           state_q;
  logic [BW-1:0]    block_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;
  logic             overrun_q;
  logic             frame_q;

  logic [BW-1:0]    block_d;
  logic [CNT_W-1:0] count_d;
  logic             fills_d;
  logic             accept_ok;
  logic             handshake;
  logic             timeout_hit;

  // Next shift value and byte count for a byte accepted this cycle; a byte taken
  // outside COLLECT always starts a new block.
  always_comb begin
    block_d   = {block_q[BW-9:0], rx_data};
    count_d   = (state_q == COLLECT) ? count_q + 1'b1 : CNT_W'(1);
    fills_d   = (count_d == CNT_W'(NUM_BYTES));
    accept_ok = rx_valid && !rx_error;
    handshake = valid_q && block_ready;
  end

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] tmo_q;
  logic            tmo_err_q;

  // A framing error in the same cycle takes precedence over the timeout.
  assign timeout_hit = (state_q == COLLECT) && !rx_valid && !rx_error &&
                       (tmo_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter; runs only while a partial block is pending.
  always_ff @(posedge clk) begin
    if (reset || state_q != COLLECT || rx_valid || timeout_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Sticky timeout flag; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_err_q <= 1'b0;
    end else if (timeout_hit) begin
      tmo_err_q <= 1'b1;
    end else if (clr_err) begin
      tmo_err_q <= 1'b0;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Block FSM: shift storage, handshake, and the overrun/frame sticky flags.
  // Clears are issued first so that a later set in the same cycle overrides them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      block_q   <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      if (clr_err) begin
        overrun_q <= 1'b0;
        frame_q   <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rx_error) begin
            frame_q <= 1'b1;
          end else if (rx_valid) begin
            block_q <= block_d;
            count_q <= count_d;
            state_q <= fills_d ? FULL : COLLECT;
            valid_q <= fills_d;
          end
        end
        COLLECT: begin
          if (rx_error) begin
            count_q <= '0;
            frame_q <= 1'b1;
            state_q <= IDLE;
          end else if (rx_valid) begin
            block_q <= block_d;
            count_q <= count_d;
            if (fills_d) begin
              state_q <= FULL;
              valid_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            count_q <= '0;
            state_q <= IDLE;
          end
        end
        FULL: begin
          if (handshake) begin
            valid_q <= 1'b0;
            if (accept_ok) begin
              block_q <= block_d;
              count_q <= count_d;
              state_q <= COLLECT;
            end else begin
              count_q <= '0;
              state_q <= IDLE;
              if (rx_error) frame_q <= 1'b1;
            end
          end else if (rx_valid) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign block_out   = block_q;
  assign block_valid = valid_q;
  assign byte_count  = count_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign frame_err   = frame_q;

endmodule

// File: tb/tb_rx_block_assembler.sv
// tb/tb_rx_block_assembler.sv - directed scoreboard bench for rx_block_assembler
module tb_rx_block_assembler;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_error;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic [4:0]   byte_count;
  logic         busy;
  logic         clr_err;
  logic         overrun;
  logic         timeout_err;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] P1 = 128'hDEADBEEFCAFEBABE1234567890ABCDEF;
  localparam logic [127:0] P2 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] P3 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  rx_block_assembler #(.NUM_BYTES(16), .TIMEOUT_CYCLES(20), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_error(rx_error), .block_out(block_out), .block_valid(block_valid),
    .block_ready(block_ready), .byte_count(byte_count), .busy(busy),
    .clr_err(clr_err), .overrun(overrun), .timeout_err(timeout_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_n(input logic [127:0] blk, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_byte(blk[127-8*i -: 8]);
      if (i < n - 1) repeat (gap) tick();
    end
  endtask

  task automatic send_block(input logic [127:0] blk, input int gap);
    exp_q.push_back(blk);
    send_n(blk, 16, gap);
  endtask

  task automatic expect_block(input string tag);
    logic [127:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty-scoreboard expected=pending-block", tag);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_valid"}, 128'(block_valid), 128'(1));
      check({tag, "_data"}, block_out, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
    block_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("rst_block", block_out, 128'(0));
    check("rst_valid", 128'(block_valid), 128'(0));
    check("rst_count", 128'(byte_count), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_flags", {125'(0), overrun, timeout_err, frame_err}, 128'(0));

    // Test 1: spaced bytes, consumer always ready
    block_ready = 1'b1;
    send_block(P1, 3);
    expect_block("t1");
    tick();
    check("t1_valid_drop", 128'(block_valid), 128'(0));
    check("t1_count", 128'(byte_count), 128'(0));
    check("t1_busy", 128'(busy), 128'(0));

    // Test 2: held block, overrun, then handshake and clear
    block_ready = 1'b0;
    send_block(P1, 3);
    expect_block("t2");
    send_byte(8'h55);
    check("t2_held", block_out, P1);
    check("t2_overrun", 128'(overrun), 128'(1));
    check("t2_count_full", 128'(byte_count), 128'(16));
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    check("t2_hs_valid", 128'(block_valid), 128'(0));
    check("t2_hs_busy", 128'(busy), 128'(0));
    check("t2_hs_count", 128'(byte_count), 128'(0));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t2_clr", 128'(overrun), 128'(0));

    // Test 3: handshake and new byte in the same cycle
    send_block(P2, 0);
    expect_block("t3");
    block_ready = 1'b1;
    send_byte(8'hA5);
    block_ready = 1'b0;
    check("t3_valid", 128'(block_valid), 128'(0));
    check("t3_busy", 128'(busy), 128'(1));
    check("t3_count", 128'(byte_count), 128'(1));
    check("t3_low", 128'(block_out[7:0]), 128'(8'hA5));
    do_reset();

    // Test 4: partial block then long idle
    send_n(P3, 5, 0);
    repeat (25) tick();
`ifdef RX_TIMEOUT_EN
    check("t4_count", 128'(byte_count), 128'(0));
    check("t4_tmo", 128'(timeout_err), 128'(1));
    check("t4_busy", 128'(busy), 128'(0));
`else
    check("t4_count", 128'(byte_count), 128'(5));
    check("t4_tmo", 128'(timeout_err), 128'(0));
    check("t4_busy", 128'(busy), 128'(1));
`endif
    do_reset();

    // Test 5: framing error aborts a partial block
    send_n(P2, 7, 1);
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    check("t5_frame", 128'(frame_err), 128'(1));
    check("t5_count", 128'(byte_count), 128'(0));
    check("t5_busy", 128'(busy), 128'(0));
    block_ready = 1'b1;
    send_block(P3, 1);
    expect_block("t5");
    check("t5_sticky", 128'(frame_err), 128'(1));
    tick();
    block_ready = 1'b0;

    // Set beats clear on the same cycle
    clr_err = 1'b1;
    rx_error = 1'b1;
    tick();
    clr_err = 1'b0;
    rx_error = 1'b0;
    check("set_beats_clr", 128'(frame_err), 128'(1));

    // Test 6: reset mid-block
    send_n(P1, 10, 0);
    check("t6_pre_count", 128'(byte_count), 128'(10));
    do_reset();
    check("t6_block", block_out, 128'(0));
    check("t6_count", 128'(byte_count), 128'(0));
    check("t6_misc", {124'(0), block_valid, busy, overrun, frame_err}, 128'(0));
    block_ready = 1'b1;
    send_block(P2, 0);
    expect_block("t6");
    tick();
    check("t6_end_count", 128'(byte_count), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_block_assembler.md
Name: rx_block_assembler

Overview:
- Serial-in/parallel-out byte assembler on the receive path. Sits directly downstream of the UART receiver and upstream of the decipher/CRC-check stage.
- Collects NUM_BYTES received bytes into one block (128 bits by default) and offers it with a valid/ready handshake.
- Detects overrun, inter-byte timeout and UART framing errors, and discards partial blocks on timeout or framing error.

Parameters:
- NUM_BYTES, 16, bytes per block; block width is 8*NUM_BYTES.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes inside a partial block.
- CNT_W, 5, width of byte_count; must hold NUM_BYTES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  byte from UART receiver.
- rx_valid  input  1  one-cycle strobe: rx_data is valid this cycle.
- rx_error  input  1  one-cycle strobe: framing error on the current byte.
- block_out  output  8*NUM_BYTES  assembled block; first received byte is in the MSB byte [8*NUM_BYTES-1 -: 8].
- block_valid  output  1  block_out is complete and stable.
- block_ready  input  1  consumer accepts the block when valid && ready.
- byte_count  output  CNT_W  bytes held in the current partial block.
- busy  output  1  high in COLLECT or FULL.
- clr_err  input  1  clears all sticky error flags.
- overrun  output  1  sticky: a byte arrived while FULL and was dropped.
- timeout_err  output  1  sticky: a partial block was discarded by timeout.
- frame_err  output  1  sticky: a block was aborted by rx_error.

Behaviour:
- Reset, synchronous: state=IDLE; block_out=0, block_valid=0, byte_count=0, busy=0, all error flags=0, timeout counter=0.
- States: IDLE, COLLECT, FULL.
- Byte storage: each accepted byte shifts in, block_out <= {block_out[8*NUM_BYTES-9:0], rx_data}; byte_count increments. Result visible the cycle after rx_valid.
- IDLE:
  - rx_valid && !rx_error: accept byte; go to COLLECT with byte_count=1.
  - rx_error: set frame_err; stay IDLE.
- COLLECT:
  - rx_valid && !rx_error: accept byte and clear the timeout counter.
  - When the accepted byte makes byte_count reach NUM_BYTES: go to FULL; block_valid=1 on the next cycle; byte_count stays NUM_BYTES. Latency is 1 cycle from the last rx_valid.
  - rx_error, with or without rx_valid: discard partial block, byte_count=0, set frame_err, go to IDLE. block_out content is don't-care.
- FULL:
  - block_out is held stable.
  - block_valid && block_ready: next cycle block_valid=0, byte_count=0, go to IDLE.
  - rx_valid in FULL without handshake: byte dropped; set overrun.
  - rx_valid in the same cycle as the handshake: byte accepted as byte 1 of the next block; go to COLLECT with byte_count=1.
- Error flag priority: set beats clear; a set event in the same cycle as clr_err leaves the flag at 1.
- Outputs: busy = (state != IDLE). block_valid is a registered output.
- Reset mid-block or in FULL: the partial or held block is discarded immediately; no handshake completes that cycle.

Optional Feature:
- RX_TIMEOUT_EN defined:
  - In COLLECT, a counter increments each cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES-1: discard partial block, byte_count=0, set timeout_err, go to IDLE.
  - The counter is idle outside COLLECT.
- RX_TIMEOUT_EN undefined:
  - No counter is synthesised; a partial block waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
1. Bytes DE AD BE EF CA FE BA BE 12 34 56 78 90 AB CD EF, 3-cycle gaps, block_ready=1 → block_out=128'hDEADBEEFCAFEBABE1234567890ABCDEF, block_valid high exactly one cycle, starting 1 cycle after the 16th strobe; byte_count returns to 0.
2. Same 16 bytes with block_ready=0, then one extra byte 0x55 → block_out unchanged, overrun=1; then raise block_ready → handshake, state IDLE, byte_count=0; pulse clr_err → overrun=0.
3. Full block held, block_ready and rx_valid (0xA5) in the same cycle → block_valid drops, state COLLECT, byte_count=1, block_out[7:0]=8'hA5.
4. RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=20: send 5 bytes then idle 25 cycles → byte_count=0, timeout_err=1, busy=0. Without the macro → byte_count stays 5, timeout_err=0.
5. After 7 bytes, pulse rx_error → frame_err=1, byte_count=0, IDLE. A following clean 16-byte block assembles correctly.
6. Assert reset after 10 bytes → next cycle all outputs 0. A following clean 16-byte block gives the expected block_out.
